// File: rtl/sram_arbiter.sv
// Three-port sequencer for a 16-bit asynchronous SRAM: setup, strobe (WAIT_CYCLES clocks), hold.
// Define SRAM_ARB_RR_EN for round-robin grants; otherwise fixed priority, port 0 highest.
module sram_arbiter #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req,
   input  logic [2:0]  we,
   input  logic [53:0] addr,
   input  logic [47:0] wdata,
   input  logic [5:0]  be,
   output logic [2:0]  ack,
   output logic [15:0] rdata,
   output logic        busy,
   output logic [17:0] ADR,
   output logic        RAMCS,
   output logic        RAMOE,
   output logic        RAMWE,
   output logic        RAMLB,
   output logic        RAMUB,
   input  logic [15:0] sram_pins_din,
   output logic [15:0] sram_pins_dout,
   output logic        sram_pins_drive
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_STROBE = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;

   localparam logic [3:0] STROBE_LAST = 4'(WAIT_CYCLES - 1);

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [1:0]  gnt;
   logic        gnt_we;
   logic [1:0]  pick;
   logic        sel_we;
   logic [17:0] sel_addr;
   logic [15:0] sel_wdata;
   logic [1:0]  sel_be;

`ifdef SRAM_ARB_RR_EN
   logic [1:0] last;
   logic [1:0] cand;
   logic       found;

   // Search the three ports starting just after the most recent grant.
   always_comb begin
      pick  = 2'd0;
      found = 1'b0;
      cand  = (last == 2'd2) ? 2'd0 : last + 2'd1;
      for (int unsigned i = 0; i < 3; i++) begin
         if (!found && req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
         cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         last <= 2'd2;
      else if (state == S_IDLE && |req)
         last <= pick;
   end
`else
   always_comb begin
      if (req[0])
         pick = 2'd0;
      else if (req[1])
         pick = 2'd1;
      else
         pick = 2'd2;
   end
`endif

   always_comb begin
      case (pick)
         2'd1: begin
            sel_we    = we[1];
            sel_addr  = addr[35:18];
            sel_wdata = wdata[31:16];
            sel_be    = be[3:2];
         end
         2'd2: begin
            sel_we    = we[2];
            sel_addr  = addr[53:36];
            sel_wdata = wdata[47:32];
            sel_be    = be[5:4];
         end
         default: begin
            sel_we    = we[0];
            sel_addr  = addr[17:0];
            sel_wdata = wdata[15:0];
            sel_be    = be[1:0];
         end
      endcase
   end

   // ADR and sram_pins_dout double as the latched request; they only change on a grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_IDLE;
         cnt             <= '0;
         gnt             <= '0;
         gnt_we          <= 1'b0;
         ADR             <= '0;
         sram_pins_dout  <= '0;
         sram_pins_drive <= 1'b0;
         RAMCS           <= 1'b1;
         RAMOE           <= 1'b1;
         RAMWE           <= 1'b1;
         RAMLB           <= 1'b1;
         RAMUB           <= 1'b1;
         ack             <= '0;
         rdata           <= '0;
         busy            <= 1'b0;
      end else begin
         ack <= '0;
         case (state)
            S_IDLE: begin
               if (|req) begin
                  state  <= S_SETUP;
                  busy   <= 1'b1;
                  gnt    <= pick;
                  gnt_we <= sel_we;
                  ADR    <= sel_addr;
                  RAMCS  <= 1'b0;
                  RAMLB  <= ~sel_be[0];
                  RAMUB  <= ~sel_be[1];
                  if (sel_we) begin
                     sram_pins_drive <= 1'b1;
                     sram_pins_dout  <= sel_wdata;
                     RAMOE           <= 1'b1;
                  end else begin
                     RAMOE <= 1'b0;
                  end
               end
            end
            S_SETUP: begin
               state <= S_STROBE;
               cnt   <= STROBE_LAST;
               if (gnt_we)
                  RAMWE <= 1'b0;
            end
            S_STROBE: begin
               if (cnt == 4'd0) begin
                  state <= S_HOLD;
                  RAMWE <= 1'b1;
                  RAMOE <= 1'b1;
                  ack   <= 3'b001 << gnt;
                  if (!gnt_we)
                     rdata <= sram_pins_din;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_HOLD: begin
               state           <= S_IDLE;
               busy            <= 1'b0;
               RAMCS           <= 1'b1;
               RAMLB           <= 1'b1;
               RAMUB           <= 1'b1;
               sram_pins_drive <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
